// File: rtl/fft16_r2_ctrl.sv
// fft16_r2_ctrl: sequencer for an in-place 16-point radix-2 DIT FFT datapath.
// On start it walks 4 stages x 8 butterflies and issues one butterfly per cycle.
// It replays each read address pair as a write-back BFLY_LAT cycles later, and it
// inserts a drain barrier between stages so no stage reads before the previous
// stage has written.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      request one transform (ignored while busy)
//   busy, done                 run in progress / one-cycle completion pulse
//   rd_en, rd_addr_a/b         butterfly issue strobe and leg addresses
//   tw_addr, rd_stage          twiddle ROM index and stage of the issued butterfly
//   wr_en, wr_addr_a/b         write-back strobe and leg addresses
//   wr_stage                   stage tag of the write-back
module fft16_r2_ctrl #(
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [3:0] rd_addr_a,
  output logic [3:0] rd_addr_b,
  output logic [2:0] tw_addr,
  output logic [1:0] rd_stage,
  output logic       wr_en,
  output logic [3:0] wr_addr_a,
  output logic [3:0] wr_addr_b,
  output logic [1:0] wr_stage
);

  localparam logic [3:0] DrainInit = 4'(BFLY_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [1:0] stage;
  } wb_t;

  state_e     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] bfly_q, bfly_d;
  logic [3:0] drain_q, drain_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_en_q, rd_en_d;
  logic [3:0] rd_a_q, rd_a_d;
  logic [3:0] rd_b_q, rd_b_d;
  logic [2:0] tw_q, tw_d;
  logic [1:0] rd_stage_q, rd_stage_d;

  wb_t        pipe_q [BFLY_LAT];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          stage_d = 2'd0;
          bfly_d  = 3'd0;
        end
      end
      StIssue: begin
        if (bfly_q == 3'd7) begin
          state_d = StDrain;
          drain_d = DrainInit;
        end else begin
          bfly_d = bfly_q + 3'd1;
        end
      end
      StDrain: begin
        if (drain_q == 4'd0) begin
          if (stage_q != 2'd3) begin
            state_d = StIssue;
            stage_d = stage_q + 2'd1;
            bfly_d  = 3'd0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read-side outputs are registered from the next state so they line up with
  // the butterfly the FSM is issuing in that cycle. Bit s of the top-leg address
  // is always 0; the butterfly index is split around it (low s bits = j).
  always_comb begin
    busy_d     = (state_d != StIdle);
    rd_en_d    = (state_d == StIssue);
    rd_a_d     = 4'd0;
    tw_d       = 3'd0;
    rd_stage_d = 2'd0;
    if (rd_en_d) begin
      rd_stage_d = stage_d;
      unique case (stage_d)
        2'd0: begin
          rd_a_d = {bfly_d, 1'b0};
          tw_d   = 3'd0;
        end
        2'd1: begin
          rd_a_d = {bfly_d[2:1], 1'b0, bfly_d[0]};
          tw_d   = {bfly_d[0], 2'b00};
        end
        2'd2: begin
          rd_a_d = {bfly_d[2], 1'b0, bfly_d[1:0]};
          tw_d   = {bfly_d[1:0], 1'b0};
        end
        default: begin
          rd_a_d = {1'b0, bfly_d};
          tw_d   = bfly_d;
        end
      endcase
    end
    rd_b_d = rd_en_d ? (rd_a_d | (4'd1 << stage_d)) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      stage_q    <= 2'd0;
      bfly_q     <= 3'd0;
      drain_q    <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_a_q     <= 4'd0;
      rd_b_q     <= 4'd0;
      tw_q       <= 3'd0;
      rd_stage_q <= 2'd0;
      for (int i = 0; i < int'(BFLY_LAT); i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      bfly_q     <= bfly_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      tw_q       <= tw_d;
      rd_stage_q <= rd_stage_d;
      // Entry k holds the issue from k+1 cycles ago; the last entry is exactly
      // BFLY_LAT cycles behind rd_en.
      pipe_q[0]  <= '{valid: rd_en_q, addr_a: rd_a_q, addr_b: rd_b_q, stage: rd_stage_q};
      for (int i = 1; i < int'(BFLY_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign rd_stage  = rd_stage_q;
  assign wr_en     = pipe_q[BFLY_LAT-1].valid;
  assign wr_addr_a = pipe_q[BFLY_LAT-1].addr_a;
  assign wr_addr_b = pipe_q[BFLY_LAT-1].addr_b;
  assign wr_stage  = pipe_q[BFLY_LAT-1].stage;

endmodule

// File: tb/tb_fft16_r2_ctrl.sv
// Scoreboard bench for fft16_r2_ctrl: the driver pushes the expected read,
// write-back and done events (with their cycle numbers) when a start is accepted;
// a monitor on the falling edge pops and compares whenever the DUT presents them.
module tb_fft16_r2_ctrl;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b1;
  logic       busy, done, rd_en, wr_en;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
  logic [1:0] rd_stage, wr_stage;

  fft16_r2_ctrl #(.BFLY_LAT(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .rd_stage  (rd_stage),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_stage  (wr_stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int   cyc = 0;
  logic rst_smp = 1'b0;
  int   run_s = 1, run_e = 0, idle_from = 0, last_t = 0;
  int   nvec = 0, nerr = 0;
  logic fin = 1'b0;
  logic fin_chk = 1'b0;
  logic [15:0] mask [4];
  int   dup = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst_n;
  end

  // Reference address model, written from the arithmetic definition.
  task automatic ref_addr(input int s, input int b, output logic [3:0] a,
                          output logic [3:0] bb, output logic [2:0] tw);
    int half, j, g;
    half = 1 << s;
    j    = b % half;
    g    = b >> s;
    a    = 4'(g * 2 * half + j);
    bb   = 4'(g * 2 * half + j + half);
    tw   = 3'((j << (3 - s)) & 7);
  endtask

  task automatic push_run(input int t);
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 8; b++) begin
        e.s = 2'(k);
        ref_addr(k, b, e.a, e.b, e.tw);
        e.cyc = t + 1 + k * (8 + L) + b;
        rd_q.push_back(e);
        e.cyc = e.cyc + L;
        e.tw  = 3'd0;
        wr_q.push_back(e);
      end
    end
    done_q.push_back(t + 33 + 4 * L);
    run_s     = t + 1;
    run_e     = t + 32 + 4 * L;
    idle_from = t + 33 + 4 * L;
  endtask

  // Drive one cycle of inputs just after the rising edge; they are sampled at the next edge.
  task automatic step(input logic st, input logic rn);
    int cur;
    @(posedge clk);
    #1;
    start = st;
    rst_n = rn;
    cur   = cyc;
    last_t = cur;
    if (!rn) begin
      while (rd_q.size() > 0 && rd_q[$].cyc > cur) void'(rd_q.pop_back());
      while (wr_q.size() > 0 && wr_q[$].cyc > cur) void'(wr_q.pop_back());
      while (done_q.size() > 0 && done_q[$] > cur) void'(done_q.pop_back());
      if (run_e > cur) run_e = cur;
      idle_from = 0;
    end else if (st && cur >= idle_from) begin
      push_run(cur);
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_smp) begin
      check("reset_outputs",
            64'({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_addr, rd_stage,
                 wr_addr_a, wr_addr_b, wr_stage}), 64'd0);
      for (int s = 0; s < 4; s++) mask[s] = 16'd0;
      dup = 0;
    end else begin
      check("busy", 64'(busy), 64'(cyc >= run_s && cyc <= run_e));
      if (rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
        else begin
          e = rd_q.pop_front();
          check("rd", {32'(cyc), 17'd0, rd_addr_a, rd_addr_b, tw_addr, rd_stage},
                      {32'(e.cyc), 17'd0, e.a, e.b, e.tw, e.s});
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        e = rd_q.pop_front();
        check("rd_missing", 64'(0), 64'(e.cyc));
      end
      if (wr_en) begin
        if ((mask[wr_stage] & ((16'd1 << wr_addr_a) | (16'd1 << wr_addr_b))) != 16'd0) dup++;
        mask[wr_stage] = mask[wr_stage] | (16'd1 << wr_addr_a) | (16'd1 << wr_addr_b);
        if (wr_q.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
        else begin
          e = wr_q.pop_front();
          check("wr", {32'(cyc), 22'd0, wr_addr_a, wr_addr_b, wr_stage},
                      {32'(e.cyc), 22'd0, e.a, e.b, e.s});
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        e = wr_q.pop_front();
        check("wr_missing", 64'(0), 64'(e.cyc));
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 64'(1), 64'(0));
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        for (int s = 0; s < 4; s++) begin
          check("stage_cover", 64'(mask[s]), 64'hffff);
          mask[s] = 16'd0;
        end
        check("wr_dup", 64'(dup), 64'd0);
        dup = 0;
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        check("done_missing", 64'(0), 64'(done_q.pop_front()));
      end
    end
    if (fin && !fin_chk) begin
      fin_chk = 1'b1;
      check("rd_left", 64'(rd_q.size()), 64'd0);
      check("wr_left", 64'(wr_q.size()), 64'd0);
      check("done_left", 64'(done_q.size()), 64'd0);
    end
  end

  initial begin
    int t;
    // Reset held with start high.
    repeat (3) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    // Full run; starts at t+5 and t+20 must be ignored.
    step(1'b1, 1'b1);
    t = last_t;
    for (int i = 1; i <= 50; i++) step(i == 5 || i == 20, 1'b1);
    // Back-to-back: start again in the done cycle (t+45).
    step(1'b1, 1'b1);
    t = last_t;
    for (int i = 1; i <= 45; i++) step(i == 45, 1'b1);
    repeat (50) step(1'b0, 1'b1);
    // Reset during stage-2 drain (t+31..t+33), then a fresh full run.
    step(1'b1, 1'b1);
    t = last_t;
    for (int i = 1; i <= 31; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (50) step(1'b0, 1'b1);
    fin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
